// File: rtl/div_clk.sv
`timescale 1ns/1ps
// div_clk: registered integer clock divider; clk_out is low for ceil(DIVISOR/2) cycles, then high.
// Optional macro DIV_CLK_TICK_EN adds a one-cycle tick on every clk_out rising edge.
module div_clk #(
    parameter int DIVISOR = 100
) (
    input  logic clk_in,
    input  logic rst,
`ifdef DIV_CLK_TICK_EN
    output logic tick,
`endif
    output logic clk_out
);

    // The guard keeps the width legal so that only the $error below fires for a bad DIVISOR.
    localparam int CNT_W = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
    localparam int HALF  = (DIVISOR + 1) / 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("div_clk: DIVISOR must be at least 2");
    end

    // Declaration values give a defined low output before the first reset.
    logic [CNT_W-1:0] cnt_reg     = '0;
    logic             clk_out_reg = 1'b0;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            clk_out_reg <= (cnt_next >= CNT_HALF);
        end
    end

    assign clk_out = clk_out_reg;

`ifdef DIV_CLK_TICK_EN
    logic tick_reg = 1'b0;

    // The count lands on HALF exactly once per period, on the edge where clk_out rises.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= (cnt_next == CNT_HALF);
        end
    end

    assign tick = tick_reg;
`endif

endmodule

// File: tb/tb_div_clk.sv
`timescale 1ns/1ps
// tb_div_clk: directed checks of div_clk with DIVISOR 100, 10, 3 and 2 sharing one clock and reset.
module tb_div_clk;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic div100_out, div10_out, div3_out, div2_out;
`ifdef DIV_CLK_TICK_EN
    logic div100_tick, div10_tick, div3_tick, div2_tick;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    int k = 0;  // posedges since power-up or since the last reset release

    always #50 clk = ~clk;

    div_clk #(.DIVISOR(100)) u_div100 (
        .clk_in(clk), .rst(rst),
`ifdef DIV_CLK_TICK_EN
        .tick(div100_tick),
`endif
        .clk_out(div100_out));
    div_clk #(.DIVISOR(10)) u_div10 (
        .clk_in(clk), .rst(rst),
`ifdef DIV_CLK_TICK_EN
        .tick(div10_tick),
`endif
        .clk_out(div10_out));
    div_clk #(.DIVISOR(3)) u_div3 (
        .clk_in(clk), .rst(rst),
`ifdef DIV_CLK_TICK_EN
        .tick(div3_tick),
`endif
        .clk_out(div3_out));
    div_clk #(.DIVISOR(2)) u_div2 (
        .clk_in(clk), .rst(rst),
`ifdef DIV_CLK_TICK_EN
        .tick(div2_tick),
`endif
        .clk_out(div2_out));

    // Edge timestamps of the power-up run, used for period and duty checks.
    longint unsigned rise10_t[2] = '{0, 0};
    longint unsigned fall10_t = 0;
    longint unsigned rise100_t = 0;
    longint unsigned fall100_t = 0;
    int rise10_n = 0;

    always @(posedge div10_out) begin
        if (rise10_n < 2) rise10_t[rise10_n] = $time;
        rise10_n++;
    end
    always @(negedge div10_out) if (fall10_t == 0) fall10_t = $time;
    always @(posedge div100_out) if (rise100_t == 0) rise100_t = $time;
    always @(negedge div100_out) if (fall100_t == 0) fall100_t = $time;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s k=%0d: got %0d (%b) expected %0d", tag, k, got, got[0], exp);
        end else begin
            checks_passed++;
        end
    endtask

    // Expected output: low for ceil(D/2) cycles of each period, then high.
    function automatic logic exp_out(input int d, input int n);
        return ((n % d) >= ((d + 1) / 2));
    endfunction

    task automatic check_all_outputs(input string phase);
        check({phase, " div100"}, 64'(div100_out), 64'(exp_out(100, k)));
        check({phase, " div10"},  64'(div10_out),  64'(exp_out(10, k)));
        check({phase, " div3"},   64'(div3_out),   64'(exp_out(3, k)));
        check({phase, " div2"},   64'(div2_out),   64'(exp_out(2, k)));
`ifdef DIV_CLK_TICK_EN
        check({phase, " tick10"}, 64'(div10_tick), 64'((k > 0) && (k % 10 == 5)));
        check({phase, " tick2"},  64'(div2_tick),  64'(k % 2 == 1));
`endif
    endtask

    task automatic run_cycles(input int n, input string phase);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            check_all_outputs(phase);
        end
    endtask

    // Assert rst at a negedge, hold it for n posedges and expect every output low throughout.
    task automatic reset_for(input int n, input string phase);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = 0;
            check({phase, " rst div100"}, 64'(div100_out), 64'd0);
            check({phase, " rst div10"},  64'(div10_out),  64'd0);
            check({phase, " rst div3"},   64'(div3_out),   64'd0);
            check({phase, " rst div2"},   64'(div2_out),   64'd0);
`ifdef DIV_CLK_TICK_EN
            check({phase, " rst tick10"}, 64'(div10_tick), 64'd0);
            check({phase, " rst tick2"},  64'(div2_tick),  64'd0);
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        // Power-up with rst low: outputs must already be a defined 0.
        #1;
        check_all_outputs("powerup");
        run_cycles(101, "t1");
        check("t1 div10 first rise",   64'(rise10_t[0]), 64'd450);
        check("t1 div10 first fall",   64'(fall10_t),    64'd950);
        check("t1 div10 period",       64'(rise10_t[1] - rise10_t[0]), 64'd1000);
        check("t1 div10 high time",    64'(fall10_t - rise10_t[0]),    64'd500);
        check("t1 div100 first rise",  64'(rise100_t), 64'd4950);
        check("t1 div100 high time",   64'(fall100_t - rise100_t), 64'd5000);

        // Single-cycle reset pulse near 10.1 us, then a fresh count from the release.
        reset_for(1, "t2");
        run_cycles(67, "t2");
        check("t3 div10 high before rst", 64'(div10_out), 64'd1);

        // Reset in the middle of div10's high phase, held for three edges.
        reset_for(3, "t3");
        run_cycles(25, "t3");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
